// File: rtl/fpu_pkg.sv
// Shared FPU result types: exception flag bundle and the stored result entry.
package fpu_pkg;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inv;
    } fpu_flags_t;

    typedef struct packed {
        logic [31:0] res;
        fpu_flags_t  flags;
    } fpu_entry_t;

    localparam int unsigned FPU_ENTRY_W   = $bits(fpu_entry_t);
    localparam int unsigned FPU_ERR_ISSUE = 0;
    localparam int unsigned FPU_ERR_DROP  = 1;

    function automatic fpu_entry_t fpu_make_entry(input logic [31:0] res,
                                                  input logic        ovf,
                                                  input logic        unf,
                                                  input logic        inv);
        fpu_entry_t e;
        e.res       = res;
        e.flags.ovf = ovf;
        e.flags.unf = unf;
        e.flags.inv = inv;
        return e;
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Storage is cleared on reset so the head reads zero until the first write.
module fpu_sync_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_result_collector.sv
// Collects results of a fixed-latency FPU pipe into a FIFO, issuing credits so
// upstream never launches more operations than the FIFO can absorb.
module fpu_result_collector
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int          L_PIPE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_issue,
    input  logic                       i_valid,
    input  logic [31:0]                i_res,
    input  logic                       i_overflow,
    input  logic                       i_underflow,
    input  logic                       i_invalid,
    output logic                       o_issue_ok,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [31:0]                o_res,
    output logic [2:0]                 o_flags,
    output logic [2:0]                 o_sticky,
    input  logic                       i_sticky_clr,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [1:0]                 o_err
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || L_PIPE < 1) begin : g_param_check
        $error("fpu_result_collector: DEPTH must be a power of two >= 2 and L_PIPE >= 1");
    end

    fpu_entry_t  wr_entry;
    fpu_entry_t  rd_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop_req;
    logic        push_ok;
    logic        drop;
    logic        issue_acc;
    logic        issue_bad;
    logic [CW:0] occupancy;

    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    fpu_flags_t    sticky_q;
    fpu_flags_t    sticky_nxt;
    logic [1:0]    err_q;
    logic [1:0]    err_nxt;

    assign wr_entry = fpu_make_entry(i_res, i_overflow, i_underflow, i_invalid);

    fpu_sync_fifo #(
        .WIDTH (FPU_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_valid),
        .pop   (pop_req),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    assign o_valid  = !fifo_empty;
    assign o_res    = rd_entry.res;
    assign o_flags  = rd_entry.flags;
    assign o_sticky = sticky_q;
    assign o_err    = err_q;

    assign pop_req = o_valid && i_ready;
    assign push_ok = i_valid && (!fifo_full || pop_req);
    assign drop    = i_valid && fifo_full && !pop_req;

    // Credits cover both stored entries and results still travelling in the pipe.
    assign occupancy  = {1'b0, o_count} + {1'b0, inflight};
    assign o_issue_ok = (occupancy < (CW+1)'(DEPTH));
    assign issue_acc  = i_issue && o_issue_ok;
    assign issue_bad  = i_issue && !o_issue_ok;

    always_comb begin
        inflight_nxt = inflight;
        if (issue_acc && !i_valid) begin
            inflight_nxt = inflight + 1'b1;
        end else if (!issue_acc && i_valid && (inflight != '0)) begin
            inflight_nxt = inflight - 1'b1;
        end
    end

    always_comb begin
        sticky_nxt = sticky_q;
        if (i_sticky_clr) begin
            sticky_nxt = '0;
        end else if (push_ok) begin
            sticky_nxt = sticky_q | wr_entry.flags;
        end
    end

    always_comb begin
        err_nxt                = err_q;
        err_nxt[FPU_ERR_DROP]  = err_q[FPU_ERR_DROP]  | drop;
        err_nxt[FPU_ERR_ISSUE] = err_q[FPU_ERR_ISSUE] | issue_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            sticky_q <= '0;
            err_q    <= '0;
        end else begin
            inflight <= inflight_nxt;
            sticky_q <= sticky_nxt;
            err_q    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Randomised scoreboard bench for fpu_result_collector with a behavioural
// model of FIFO occupancy, credits, sticky flags and error bits.
module tb_fpu_result_collector;

    localparam int DEPTH  = 8;
    localparam int L_PIPE = 3;
    localparam int CW     = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_issue = 1'b0;
    logic          i_valid = 1'b0;
    logic [31:0]   i_res = '0;
    logic          i_overflow = 1'b0;
    logic          i_underflow = 1'b0;
    logic          i_invalid = 1'b0;
    logic          o_issue_ok;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [31:0]   o_res;
    logic [2:0]    o_flags;
    logic [2:0]    o_sticky;
    logic          i_sticky_clr = 1'b0;
    logic [CW-1:0] o_count;
    logic [1:0]    o_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          mcount = 0;
    int          minfl = 0;
    logic [2:0]  msticky = '0;
    logic [1:0]  merr = '0;
    logic [34:0] expq[$];

    // Upstream pipe model
    logic        pv [L_PIPE];
    logic [34:0] pe [L_PIPE];
    int          issued = 0;
    bit          checker_on = 1'b0;

    fpu_result_collector #(
        .DEPTH  (DEPTH),
        .L_PIPE (L_PIPE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_issue      (i_issue),
        .i_valid      (i_valid),
        .i_res        (i_res),
        .i_overflow   (i_overflow),
        .i_underflow  (i_underflow),
        .i_invalid    (i_invalid),
        .o_issue_ok   (o_issue_ok),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_res        (o_res),
        .o_flags      (o_flags),
        .o_sticky     (o_sticky),
        .i_sticky_clr (i_sticky_clr),
        .o_count      (o_count),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: evaluates what the collector must do at each edge.
    initial begin
        bit pop, push, iss;
        forever begin
            @(posedge clk);
            if (rst) begin
                mcount  = 0;
                minfl   = 0;
                msticky = '0;
                merr    = '0;
                expq.delete();
            end else begin
                pop  = (mcount != 0) && i_ready;
                push = i_valid && ((mcount < DEPTH) || pop);
                iss  = i_issue && ((mcount + minfl) < DEPTH);
                if (i_issue && !iss) merr[0] = 1'b1;
                if (i_valid && !push) merr[1] = 1'b1;
                if (push) expq.push_back({i_res, i_overflow, i_underflow, i_invalid});
                mcount = mcount + int'(push) - int'(pop);
                if (iss && !i_valid) minfl++;
                else if (!iss && i_valid && minfl > 0) minfl--;
                if (i_sticky_clr) msticky = '0;
                else if (push) msticky = msticky | {i_overflow, i_underflow, i_invalid};
            end
        end
    end

    // Monitor: every head handed downstream must match the oldest expected entry.
    initial begin
        logic [34:0] exp_e;
        forever begin
            @(negedge clk);
            if (!rst && o_valid && i_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_unexpected: got %0h expected no entry at %0t", {o_res, o_flags}, $time);
                end else begin
                    exp_e = expq.pop_front();
                    checkOutput("head_entry", {29'd0, o_res, o_flags}, {29'd0, exp_e});
                end
            end
        end
    end

    // Per-cycle state comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checker_on) begin
                checkOutput("count", 64'(o_count), 64'(mcount));
                checkOutput("valid", 64'(o_valid), 64'(mcount != 0));
                checkOutput("issue_ok", 64'(o_issue_ok), 64'((mcount + minfl) < DEPTH));
                checkOutput("sticky", 64'(o_sticky), 64'(msticky));
                checkOutput("err", 64'(o_err), 64'(merr));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset(input int ncyc);
        rst          = 1'b1;
        i_issue      = 1'b0;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_sticky_clr = 1'b0;
        for (int k = 0; k < L_PIPE; k++) begin
            pv[k] = 1'b0;
            pe[k] = '0;
        end
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one cycle of upstream traffic through the fixed-latency pipe.
    task automatic applyStimulus(input bit want_issue, input bit ready, input bit clr, input bit force_issue);
        bit iss;
        iss     = want_issue && (o_issue_ok || force_issue);
        i_issue = iss;
        i_valid = pv[L_PIPE-1];
        {i_res, i_overflow, i_underflow, i_invalid} = pe[L_PIPE-1];
        for (int k = L_PIPE - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pe[k] = pe[k-1];
        end
        pv[0] = iss && o_issue_ok;
        pe[0] = {32'($urandom), 3'($urandom_range(0, 7))};
        if (iss && o_issue_ok) issued++;
        i_ready      = ready;
        i_sticky_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic applyRaw(input bit valid, input logic [31:0] res, input logic [2:0] fl, input bit ready, input bit clr);
        i_issue      = 1'b0;
        i_valid      = valid;
        i_res        = res;
        {i_overflow, i_underflow, i_invalid} = fl;
        i_ready      = ready;
        i_sticky_clr = clr;
        @(posedge clk);
        #1;
        i_valid      = 1'b0;
        i_sticky_clr = 1'b0;
    endtask

    initial begin
        int n;
        doReset(2);
        checker_on = 1'b1;
        $display("[TB] reset state");
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_issue_ok", 64'(o_issue_ok), 64'd1);
        checkOutput("rst_count", 64'(o_count), 64'd0);
        checkOutput("rst_sticky", 64'(o_sticky), 64'd0);
        checkOutput("rst_err", 64'(o_err), 64'd0);
        checkOutput("rst_res", 64'(o_res), 64'd0);
        checkOutput("rst_flags", 64'(o_flags), 64'd0);

        $display("[TB] credit limit");
        issued = 0;
        repeat (20 + L_PIPE) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("credit_issues", 64'(issued), 64'd8);
        checkOutput("credit_count", 64'(o_count), 64'd8);
        checkOutput("credit_issue_ok", 64'(o_issue_ok), 64'd0);
        checkOutput("credit_err", 64'(o_err), 64'd0);

        $display("[TB] drain and refill while full");
        for (int k = 0; k < 20; k++) begin
            applyRaw(1'b1, $urandom, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        end
        checkOutput("refill_count", 64'(o_count), 64'd8);
        checkOutput("refill_err", 64'(o_err), 64'd0);

        $display("[TB] drop on full");
        applyRaw(1'b1, 32'h3F800000, 3'b000, 1'b0, 1'b0);
        checkOutput("drop_count", 64'(o_count), 64'd8);
        checkOutput("drop_err", 64'(o_err), 64'b10);

        $display("[TB] issue violation");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("viol_err", 64'(o_err), 64'b11);
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain_count", 64'(o_count), 64'd0);

        $display("[TB] sticky flags");
        doReset(1);
        applyRaw(1'b1, 32'h1111_0000, 3'b100, 1'b1, 1'b0);
        applyRaw(1'b1, 32'h2222_0000, 3'b001, 1'b1, 1'b0);
        checkOutput("sticky_or", 64'(o_sticky), 64'b101);
        applyRaw(1'b1, 32'h3333_0000, 3'b010, 1'b1, 1'b1);
        checkOutput("sticky_clr_wins", 64'(o_sticky), 64'd0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] mid-run reset");
        doReset(1);
        n = 0;
        while (o_count != CW'(5) && n < 30) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput("midrst_reached5", 64'(o_count), 64'd5);
        checkOutput("midrst_credit_full", 64'(o_issue_ok), 64'd0);
        doReset(1);
        checkOutput("midrst_count", 64'(o_count), 64'd0);
        checkOutput("midrst_issue_ok", 64'(o_issue_ok), 64'd1);
        issued = 0;
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_reissue", 64'(issued), 64'd8);

        $display("[TB] randomised traffic");
        doReset(2);
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0, 1'b0);
        end
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("final_count", 64'(o_count), 64'd0);
        checkOutput("final_scoreboard", 64'(expq.size()), 64'd0);

        checker_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_result_collector.md
FPU_RESULT_COLLECTOR -- requirements
Module: fpu_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter L_PIPE, default 3, meaning latency of the upstream fixed-latency FPU pipe (informational; credit scheme is latency-independent).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_issue  input  1  upstream launched one operation into the FPU pipe this cycle.
REQ-006 SHALL have port i_valid  input  1  result strobe from pipe valid_out; no backpressure possible.
REQ-007 SHALL have port i_res  input  32  IEEE-754 single result.
REQ-008 SHALL have ports i_overflow, i_underflow, i_invalid  input  1 each  result exception flags.
REQ-009 SHALL have port o_issue_ok  output  1  upstream may assert i_issue this cycle.
REQ-010 SHALL have port o_valid  output  1  head entry available downstream.
REQ-011 SHALL have port i_ready  input  1  downstream accepts head.
REQ-012 SHALL have port o_res  output  32  head result.
REQ-013 SHALL have port o_flags  output  3  head flags {ovf,unf,inv}.
REQ-014 SHALL have port o_sticky  output  3  OR of flags of all accepted results since reset/clear.
REQ-015 SHALL have port i_sticky_clr  input  1  clears o_sticky.
REQ-016 SHALL have port o_count  output  $clog2(DEPTH+1)  stored entries.
REQ-017 SHALL have port o_err  output  2  sticky errors {drop, issue_violation}.

Function
REQ-018 SHALL store each i_valid beat (res+flags) in a FIFO, in arrival order, same-cycle write.
REQ-019 SHALL be first-word-fall-through: o_valid=(count!=0), o_res/o_flags = head combinationally from storage.
REQ-020 SHALL pop head on cycle where o_valid && i_ready; pop with o_valid=0 ignored.
REQ-021 SHALL keep inflight counter (width $clog2(DEPTH+1)): +1 on accepted i_issue, -1 on i_valid, unchanged if both, saturate at 0 on i_valid with inflight=0.
REQ-022 SHALL drive o_issue_ok = (count + inflight) < DEPTH, combinational from registers only (no dependence on same-cycle i_ready/i_valid).
REQ-023 SHALL treat i_issue while o_issue_ok=0 as violation: not counted into inflight, set o_err[0].
REQ-024 SHALL on i_valid with FIFO full and no same-cycle pop drop the beat, leave FIFO unchanged, set o_err[1].
REQ-025 SHALL with FIFO full and same-cycle pop+push accept both; count unchanged.
REQ-026 SHALL with FIFO empty and same-cycle push accept push only (no bypass); o_valid rises next cycle.
REQ-027 SHALL update count: +1 push only, -1 pop only, unchanged both/neither.
REQ-028 SHALL wrap read/write pointers modulo DEPTH.
REQ-029 SHALL OR accepted flags into o_sticky next cycle; i_sticky_clr same cycle as flagged push: clear wins, o_sticky=0.
REQ-030 SHALL keep o_err bits set until reset.

Reset
REQ-031 SHALL, when rst=1 at clk edge, clear count, pointers, inflight, o_sticky, o_err; outputs then o_valid=0, o_issue_ok=1, o_count=0, o_res=0, o_flags=0.
REQ-032 SHALL ignore all inputs during rst; results of ops in flight across reset are lost (upstream pipe reset concurrently).
REQ-033 SHALL zero storage array on reset so o_res reads 0 when empty.

Structure
REQ-034 SHALL take fpu_flags_t (packed ovf,unf,inv) and fpu_entry_t (res + flags) from shared package fpu_pkg.
REQ-035 SHALL instantiate sub-module fpu_sync_fifo (parameterised width/depth, FWFT, count output); credit, sticky, error logic in top.

Verification
REQ-036 Reset: rst=1 two cycles -> o_valid=0, o_issue_ok=1, o_count=0, o_sticky=0, o_err=0.
REQ-037 Credit: DEPTH=8, i_ready=0, issue every cycle while o_issue_ok -> exactly 8 issues, o_issue_ok=0 thereafter, 8 results stored in order, o_count=8, o_err=0.
REQ-038 Drain/refill: full FIFO, i_ready=1 with i_valid each cycle for 20 cycles -> count stays 8, output order equals input order, no drop.
REQ-039 Drop: force i_valid with count=8, i_ready=0, i_res=0x3F800000 -> FIFO unchanged, o_err=2'b10.
REQ-040 Sticky: push flags 3'b100 then 3'b001 -> o_sticky=3'b101; i_sticky_clr coincident with flag 3'b010 push -> o_sticky=0.
REQ-041 Mid-run reset: count=5, inflight=3, assert rst -> next cycle count=0, inflight=0, o_issue_ok=1.
